// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
// systolic_result_drain : sweeps array selects, streams results row-major
// Revision 1.0
// ============================================================================
module systolic_result_drain #(
    parameter int SIZE  = 16,
    parameter int NBITS = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] out_rsel,
    output logic [((SIZE > 1) ? $clog2(SIZE) : 1)-1:0] out_csel,
    input  logic [NBITS-1:0]                    b_s_in,
    output logic                                send_val,
    input  logic                                send_rdy,
    output logic [NBITS-1:0]                    send_msg,
    output logic                                send_last
);

    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [IW-1:0] C_MAX = IW'(SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_free;
    logic   w_capture;
    logic   w_final;
    logic   w_xfer;

    // Register can be refilled in the same cycle its current word leaves
    assign w_free    = !send_val || send_rdy;
    assign w_xfer    = send_val && send_rdy;
    assign w_capture = (r_state == S_DRAIN) && w_free;
    assign w_final   = (out_rsel == C_MAX) && (out_csel == C_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_capture && w_final) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (w_xfer && send_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Row-major select sweep; selects only move when a word is captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_rsel <= '0;
            out_csel <= '0;
        end else if (w_capture) begin
            if (w_final) begin
                out_rsel <= '0;
                out_csel <= '0;
            end else if (out_csel == C_MAX) begin
                out_csel <= '0;
                out_rsel <= out_rsel + IW'(1);
            end else begin
                out_csel <= out_csel + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            send_val  <= 1'b0;
            send_msg  <= '0;
            send_last <= 1'b0;
        end else if (w_capture) begin
            send_val  <= 1'b1;
            send_msg  <= b_s_in;
            send_last <= w_final;
        end else if (w_xfer) begin
            send_val  <= 1'b0;
            send_last <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
// tb_systolic_result_drain : table-driven drains with a word scoreboard
// Revision 1.0
// ============================================================================
module tb_systolic_result_drain;

    localparam int SIZE  = 4;
    localparam int NBITS = 16;
    localparam int IW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic [IW-1:0]    out_rsel;
    logic [IW-1:0]    out_csel;
    logic [NBITS-1:0] b_s_in;
    logic             send_val;
    logic             send_rdy;
    logic [NBITS-1:0] send_msg;
    logic             send_last;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Array model: M[r][c] = 16*r + c
    assign b_s_in = NBITS'(32'(out_rsel) * 16 + 32'(out_csel));

    systolic_result_drain #(.SIZE(SIZE), .NBITS(NBITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .out_rsel  (out_rsel),
        .out_csel  (out_csel),
        .b_s_in    (b_s_in),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .send_msg  (send_msg),
        .send_last (send_last)
    );

    typedef struct {
        string    name;
        logic [3:0] rdy_pat;
        int       restart_cyc;
        bit       start_on_done;
        bit       end_stall;
        int       exp_done;
        int       post;
    } vec_t;

    vec_t tbl[6];
    logic [NBITS:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic run_drain(input int idx);
        vec_t v;
        int done_cyc = -1;
        int last_x   = -1;
        int ndone    = 0;
        int nx       = 0;
        int stall    = 0;
        bit stall_started = 0;
        logic pv = 0, pr = 0, pl = 0, rdy;
        logic [NBITS-1:0] pm = '0;
        logic [NBITS:0] e;
        v = tbl[idx];
        sb.delete();
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                sb.push_back({(r == SIZE-1) && (c == SIZE-1), NBITS'(16*r + c)});
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                chk({v.name, "_idle_busy"}, busy, 0);
                chk({v.name, "_idle_val"}, send_val, 0);
                chk({v.name, "_idle_sel"}, {out_rsel, out_csel}, 0);
            end
            chk({v.name, "_sel_range"}, (out_rsel <= 3) && (out_csel <= 3), 1);
            if (pv && !pr) begin
                chk({v.name, "_hold_val"}, send_val, 1);
                chk({v.name, "_hold_msg"}, send_msg, pm);
                chk({v.name, "_hold_last"}, send_last, pl);
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            chk({v.name, "_busy"}, busy, (cyc >= 1) && (done_cyc < 0));
            if (done_cyc >= 0) chk({v.name, "_post_val"}, send_val, 0);
            if (v.end_stall) begin
                if (send_val && send_last && !stall_started) begin
                    stall_started = 1;
                    stall = 5;
                end
                rdy = (stall > 0) ? 1'b0 : 1'b1;
                if (stall > 0) stall--;
            end else begin
                rdy = v.rdy_pat[cyc % 4];
            end
            start    = (cyc == 0) || (cyc == v.restart_cyc) || (v.start_on_done && done);
            send_rdy = rdy;
            if (send_val && rdy) begin
                nx++;
                last_x = cyc;
                if (sb.size() == 0) begin
                    chk({v.name, "_extra_word"}, 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({v.name, "_msg"}, send_msg, e[NBITS-1:0]);
                    chk({v.name, "_last"}, send_last, e[NBITS]);
                end
            end
            pv = send_val; pr = rdy; pm = send_msg; pl = send_last;
            if (done_cyc >= 0 && cyc >= done_cyc + v.post) break;
        end
        start = 1'b0;
        if (done_cyc < 0) chk({v.name, "_timeout"}, 0, 1);
        chk({v.name, "_words"}, nx, SIZE*SIZE);
        chk({v.name, "_done_pulses"}, ndone, 1);
        chk({v.name, "_done_after_last"}, done_cyc, last_x + 1);
        if (v.exp_done > 0) chk({v.name, "_done_cycle"}, done_cyc, v.exp_done);
    endtask

    initial begin
        tbl[0] = '{"basic",        4'b1111, -1, 1'b0, 1'b0, 18, 2};
        tbl[1] = '{"backpressure", 4'b1001, -1, 1'b0, 1'b0,  0, 2};
        tbl[2] = '{"end_stall",    4'b1111, -1, 1'b0, 1'b1, 23, 2};
        tbl[3] = '{"start_busy",   4'b1111,  6, 1'b1, 1'b0, 18, 3};
        tbl[4] = '{"b2b_first",    4'b1111, -1, 1'b0, 1'b0, 18, 0};
        tbl[5] = '{"b2b_second",   4'b1111, -1, 1'b0, 1'b0, 18, 2};

        rst = 1'b1; start = 1'b0; send_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_val", send_val, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sel", {out_rsel, out_csel}, 0);
        chk("reset_msg", send_msg, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_drain(i);

        // Reset in the middle of a drain, then a fresh full drain
        @(posedge clk); #1;
        start = 1'b1; send_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_val", send_val, 1);
        rst = 1'b1;
        #1;
        chk("rst_val", send_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", {out_rsel, out_csel}, 0);
        chk("rst_last", send_last, 0);
        chk("rst_msg", send_msg, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_hold_busy", busy, 0);
        run_drain(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
